mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Moore FSM that sequences the shared MIPS datapath as a multi-cycle machine.
//  - One memory, one ALU and one register file are reused across cycles; this block drives
//    every mux select and write enable of that datapath.
//  - Instructions: R-type (op 000000), lw (100011), sw (101011), beq (000100), j (000010).
//  - Sits beside the datapath top. Takes the IR opcode and a memory-ready handshake.
//    Produces the control vector, a retire pulse and a retired-instruction count.
// PARAMETERS
//  CNT_W      32   width of retired-instruction counter (wraps modulo 2^CNT_W)
//  OP_W        6   opcode field width (fixed by ISA; do not override)
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      synchronous, active-high reset
//  enable         in   1      leave IDLE and start fetching; sampled in IDLE only
//  opcode         in   OP_W   IR[31:26], valid from DECODE onward
//  mem_ready      in   1      memory completed the access this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load qualified by ALU zero (beq)
//  i_or_d         out  1      memory address select: 0 = PC, 1 = ALUOut
//  mem_read       out  1      memory read strobe
//  mem_write      out  1      memory write strobe
//  ir_write       out  1      load instruction register
//  mem_to_reg     out  1      register write data: 0 = ALUOut, 1 = MDR
//  reg_dst        out  1      destination register: 0 = rt, 1 = rd
//  reg_write      out  1      register-file write enable
//  alu_src_a      out  1      ALU A input: 0 = PC, 1 = register A
//  alu_src_b      out  2      ALU B input: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
//  alu_op         out  2      00 = add, 01 = sub, 10 = use funct
//  pc_source      out  2      next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  instr_done     out  1      one-cycle pulse in the last state of each instruction
//  illegal_op     out  1      sticky flag: unsupported opcode was decoded
//  instr_count    out  CNT_W  number of retired instructions
//  state_dbg      out  4      current state encoding
// BEHAVIOUR
//  - State register and counter update on posedge clock.
//  - All control outputs are a pure function of the state register (Moore).
//  - reset=1: next state IDLE, instr_count=0, illegal_op=0.
//    Every control output is 0 in IDLE; reset overrides all other inputs.
//  - Reset asserted mid-instruction aborts that instruction. No write strobe is issued
//    in the cycle after reset is sampled.
//  - States (4-bit encoding):
//    IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6,
//    EXEC=7, R_WB=8, BRANCH=9, JUMP=10, TRAP=11
//  - IDLE: goes to FETCH when enable=1, otherwise stays.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//    While mem_ready=0: stay in FETCH; ir_write and pc_write are 0.
//    When mem_ready=1: ir_write=1 and pc_write=1 in that cycle, then go to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Branch on opcode:
//    lw or sw -> MEM_ADDR; R-type -> EXEC; beq -> BRANCH; j -> JUMP; any other -> TRAP.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
//    Goes to MEM_RD for lw, MEM_WR for sw (opcode is held stable by the IR).
//  - MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1, then FETCH.
//  - MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1.
//    instr_done=1 in the ready cycle only, then FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB.
//  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, then FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01,
//    instr_done=1, then FETCH.
//  - JUMP: pc_write=1, pc_source=10, instr_done=1, then FETCH.
//  - TRAP: sets illegal_op=1. All strobes are 0. The FSM stays in TRAP until reset.
//  - enable is ignored outside IDLE; deasserting it never pauses an instruction.
//  - instr_count increments by 1 on every cycle with instr_done=1 and wraps from all-ones to 0.
//  - Latency without memory wait states, counted from the FETCH entry cycle:
//    lw 5 cycles, sw 4, R-type 4, beq 3, j 3.
//    Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle.
//  - Mutual exclusion holds in every state: mem_read and mem_write are never both 1,
//    and pc_write and pc_write_cond are never both 1.
// STRUCTURE
//  - Shared package mips_pkg holds the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J),
//    the state encoding localparams, and the alu_src_b / alu_op / pc_source codes.
//  - One sub-module, mips_ctrl_decode: purely combinational state -> control-vector table.
//  - The parent owns the state register, next-state logic, counter and illegal_op flag.
// TESTING
//  1. reset=1 for 2 cycles, enable=0 -> state_dbg=0, all outputs 0, instr_count=0.
//     Release reset -> stays in IDLE.
//  2. enable=1, opcode=000000, mem_ready=1 -> states 1,2,7,8,1.
//     reg_write=1 and reg_dst=1 in R_WB; instr_count=1.
//  3. opcode=100011, mem_ready=0 for 2 cycles in MEM_RD ->
//     7 cycles FETCH->FETCH; mem_to_reg=1 in MEM_WB; instr_done pulses once.
//  4. opcode=000100 -> BRANCH with pc_write_cond=1, alu_op=01, pc_source=01, then FETCH.
//     opcode=000010 -> JUMP with pc_write=1, pc_source=10.
//  5. opcode=111111 in DECODE -> TRAP, illegal_op=1, holds for 10 cycles.
//     reset -> IDLE, illegal_op=0.
//  6. Preload instr_count to all-ones by forcing, retire 1 instruction -> count=0.
//     Assert reset during MEM_WR -> mem_write=0 on the next cycle, state=IDLE.

Source files
------------

// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, state
// encoding, datapath select codes and the packed control vector.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface mips_multicycle_control_if
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic                enable;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_source;
    logic                instr_done;
    logic                illegal_op;
    logic [CNT_W-1:0]    instr_count;
    logic [3:0]          state_dbg;

    modport master (
        input  enable, opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, instr_count, state_dbg
    );

    modport slave (
        output enable, opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, instr_count, state_dbg
    );

endinterface

// File: rtl/mips_multicycle_control_decode.sv
// State -> control-vector table. Only FETCH and MEM_WR look at mem_ready,
// to qualify the IR/PC load and the store-retire pulse.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCS_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCS_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCS_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, instruction sequencing,
// retired-instruction counter and sticky illegal-opcode flag.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned OP_W  = OPCODE_W
)(
    input  logic                      clock,
    input  logic                      reset,
    mips_multicycle_control_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;
    logic [OP_W-1:0]  op;
    ctrl_t            ctrl;

    assign op = bus.opcode;

    mips_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = ctrl.instr_done ? count_q + CNT_ONE : count_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:     if (bus.enable) state_d = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) state_d = S_MEM_ADDR;
                else if (op == OP_RTYPE)        state_d = S_EXEC;
                else if (op == OP_BEQ)          state_d = S_BRANCH;
                else if (op == OP_J)            state_d = S_JUMP;
                else                            state_d = S_TRAP;
            end
            // IR holds the opcode, so it still distinguishes lw from sw here
            S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
        if (state_d == S_TRAP) illegal_d = 1'b1;
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.instr_done    = ctrl.instr_done;
    assign bus.illegal_op    = illegal_q;
    assign bus.instr_count   = count_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle vector table plus
// hand sequences for trap hold, counter wrap and reset during a store.
module tb_mips_multicycle_control;

    localparam int unsigned CW = 4;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    // {pcw,pcc,iod,mr,mw,irw,m2r,rdst,rw,asa}, alu_src_b, alu_op, pc_source, instr_done
    localparam logic [16:0] C_ZERO = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_FW   = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_FG   = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_DEC  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_MA   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_MRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_MWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [16:0] C_WRW  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_WRG  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [16:0] C_EX   = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [16:0] C_RWB  = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [16:0] C_BR   = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b1};
    localparam logic [16:0] C_JP   = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b1};

    typedef struct {
        logic        rst;
        logic        en;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
        int unsigned cnt;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mips_multicycle_control_if #(.CNT_W(CW)) bus ();

    mips_multicycle_control #(.CNT_W(CW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    logic [16:0] act_ctl;
    assign act_ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                      bus.pc_source, bus.instr_done};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [5:0] o, input logic rd,
                       input logic [3:0] s, input logic [16:0] c, input int unsigned n,
                       input logic il);
        vecs.push_back('{rst: r, en: e, op: o, rdy: rd, st: s, ctl: c, cnt: n, ill: il});
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Runs until instr_done is seen, then one more cycle so the count has updated.
    task automatic retire(input logic [5:0] o, input string nm);
        int unsigned cyc = 0;
        bus.opcode    = o;
        bus.mem_ready = 1'b1;
        bus.enable    = 1'b1;
        do begin
            step();
            cyc++;
        end while (!bus.instr_done && cyc < 20);
        chk({nm, "_done_seen"}, 32'(bus.instr_done), 32'd1);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable    = 1'b0;
        bus.opcode    = RT;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        //   rst   en    op   rdy   state  ctl     cnt ill
        add(1'b1, 1'b0, RT,  1'b0, 4'd0,  C_ZERO, 0, 1'b0);
        add(1'b0, 1'b0, RT,  1'b0, 4'd0,  C_ZERO, 0, 1'b0);
        add(1'b0, 1'b0, RT,  1'b1, 4'd0,  C_ZERO, 0, 1'b0);
        add(1'b0, 1'b1, RT,  1'b1, 4'd0,  C_ZERO, 0, 1'b0);
        add(1'b0, 1'b0, RT,  1'b1, 4'd1,  C_FG,   0, 1'b0);
        add(1'b0, 1'b0, RT,  1'b1, 4'd2,  C_DEC,  0, 1'b0);
        add(1'b0, 1'b0, RT,  1'b1, 4'd7,  C_EX,   0, 1'b0);
        add(1'b0, 1'b0, RT,  1'b1, 4'd8,  C_RWB,  0, 1'b0);
        add(1'b0, 1'b0, LW,  1'b1, 4'd1,  C_FG,   1, 1'b0);
        add(1'b0, 1'b0, LW,  1'b1, 4'd2,  C_DEC,  1, 1'b0);
        add(1'b0, 1'b0, LW,  1'b1, 4'd3,  C_MA,   1, 1'b0);
        add(1'b0, 1'b0, LW,  1'b0, 4'd4,  C_MRD,  1, 1'b0);
        add(1'b0, 1'b0, LW,  1'b0, 4'd4,  C_MRD,  1, 1'b0);
        add(1'b0, 1'b0, LW,  1'b1, 4'd4,  C_MRD,  1, 1'b0);
        add(1'b0, 1'b0, LW,  1'b1, 4'd5,  C_MWB,  1, 1'b0);
        add(1'b0, 1'b0, BEQ, 1'b1, 4'd1,  C_FG,   2, 1'b0);
        add(1'b0, 1'b0, BEQ, 1'b1, 4'd2,  C_DEC,  2, 1'b0);
        add(1'b0, 1'b0, BEQ, 1'b1, 4'd9,  C_BR,   2, 1'b0);
        add(1'b0, 1'b0, JMP, 1'b1, 4'd1,  C_FG,   3, 1'b0);
        add(1'b0, 1'b0, JMP, 1'b1, 4'd2,  C_DEC,  3, 1'b0);
        add(1'b0, 1'b0, JMP, 1'b1, 4'd10, C_JP,   3, 1'b0);
        add(1'b0, 1'b0, SW,  1'b0, 4'd1,  C_FW,   4, 1'b0);
        add(1'b0, 1'b0, SW,  1'b1, 4'd1,  C_FG,   4, 1'b0);
        add(1'b0, 1'b0, SW,  1'b1, 4'd2,  C_DEC,  4, 1'b0);
        add(1'b0, 1'b0, SW,  1'b1, 4'd3,  C_MA,   4, 1'b0);
        add(1'b0, 1'b0, SW,  1'b0, 4'd6,  C_WRW,  4, 1'b0);
        add(1'b0, 1'b0, SW,  1'b1, 4'd6,  C_WRG,  4, 1'b0);
        add(1'b0, 1'b0, BAD, 1'b1, 4'd1,  C_FG,   5, 1'b0);
        add(1'b0, 1'b0, BAD, 1'b1, 4'd2,  C_DEC,  5, 1'b0);
        add(1'b0, 1'b1, BAD, 1'b1, 4'd11, C_ZERO, 5, 1'b1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.enable    = vecs[i].en;
            bus.opcode    = vecs[i].op;
            bus.mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_state", i), 32'(bus.state_dbg), 32'(vecs[i].st));
            chk($sformatf("v%0d_ctl", i), 32'(act_ctl), 32'(vecs[i].ctl));
            chk($sformatf("v%0d_count", i), 32'(bus.instr_count), vecs[i].cnt % 16);
            chk($sformatf("v%0d_illegal", i), 32'(bus.illegal_op), 32'(vecs[i].ill));
            chk($sformatf("v%0d_excl", i),
                32'({bus.mem_read & bus.mem_write, bus.pc_write & bus.pc_write_cond}), 32'd0);
        end

        // TRAP holds regardless of enable/mem_ready until reset
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = i[0];
            bus.enable    = ~i[0];
            step();
            chk($sformatf("trap%0d_state", i), 32'(bus.state_dbg), 32'd11);
            chk($sformatf("trap%0d_illegal", i), 32'(bus.illegal_op), 32'd1);
            chk($sformatf("trap%0d_ctl", i), 32'(act_ctl), 32'(C_ZERO));
        end
        bus.enable = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("trap_reset_state", 32'(bus.state_dbg), 32'd0);
        chk("trap_reset_illegal", 32'(bus.illegal_op), 32'd0);
        chk("trap_reset_count", 32'(bus.instr_count), 32'd0);

        // Counter wrap: 15 retires reach all-ones, the 16th wraps to zero
        for (int i = 0; i < 15; i++) retire(JMP, $sformatf("wrapj%0d", i));
        chk("count_all_ones", 32'(bus.instr_count), 32'd15);
        retire(JMP, "wrapj15");
        chk("count_wrapped", 32'(bus.instr_count), 32'd0);
        chk("wrap_in_fetch", 32'(bus.state_dbg), 32'd1);

        // Store stalled in MEM_WR, then reset aborts it
        bus.opcode    = SW;
        bus.mem_ready = 1'b1;
        step();
        chk("sw_decode", 32'(bus.state_dbg), 32'd2);
        step();
        chk("sw_mem_addr", 32'(bus.state_dbg), 32'd3);
        bus.mem_ready = 1'b0;
        step();
        chk("sw_mem_wr", 32'(bus.state_dbg), 32'd6);
        chk("sw_mem_write_on", 32'(bus.mem_write), 32'd1);
        chk("sw_no_done_wait", 32'(bus.instr_done), 32'd0);
        rst = 1'b1;
        step();
        chk("abort_state", 32'(bus.state_dbg), 32'd0);
        chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
        chk("abort_ctl", 32'(act_ctl), 32'(C_ZERO));
        rst = 1'b0;
        bus.enable = 1'b0;
        step();
        chk("post_abort_idle", 32'(bus.state_dbg), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
